// File: rtl/comparator_seq_ctrl.sv
// Sequential magnitude comparator: walks latched operands MSB-first in 2-bit
// slices through an external slice comparator and reports A==B / A>B / A<B.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; last result held on e/g/l
// COMPARE | presenting slice idx of latched A/B, decoding slice result
// DONE    | one-cycle done pulse, then back to IDLE
module comparator_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       sl_a,
  output logic [1:0]       sl_b,
  input  logic             sl_e,
  input  logic             sl_g,
  input  logic             sl_l,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             l
);

  localparam int NSL   = WIDTH / 2;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  dec_t             dec;

  // Slice mux; idle slices read as zero so the external comparator sees a quiet bus.
  always_comb begin
    sl_a = 2'b00;
    sl_b = 2'b00;
    if (state == COMPARE) begin
      for (int i = 0; i < NSL; i++) begin
        if (idx == IDX_W'(i)) begin
          sl_a = a_q[2*i +: 2];
          sl_b = b_q[2*i +: 2];
        end
      end
    end
  end

  // Greater wins over less; with no flag asserted the slice counts as equal.
  always_comb begin
    dec = DEC_EQ;
    if (sl_g)      dec = DEC_GT;
    else if (sl_l) dec = DEC_LT;
    else if (sl_e) dec = DEC_EQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      e     <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_W'(NSL - 1);
            e     <= 1'b0;
            g     <= 1'b0;
            l     <= 1'b0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          case (dec)
            DEC_GT: begin
              g     <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
            DEC_LT: begin
              l     <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
            default: begin
              if (idx == '0) begin
                e     <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx <= idx - IDX_W'(1);
              end
            end
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Directed bench for comparator_seq_ctrl (WIDTH=8) with an ideal 2-bit slice
// comparator attached; expected results and cycle counts are hand-computed.
module tb_comparator_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] sl_a;
  logic [1:0] sl_b;
  logic       sl_e;
  logic       sl_g;
  logic       sl_l;
  logic       busy;
  logic       done;
  logic       e;
  logic       g;
  logic       l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sl_e = (sl_a == sl_b);
  assign sl_g = (sl_a >  sl_b);
  assign sl_l = (sl_a <  sl_b);

  comparator_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .sl_a(sl_a), .sl_b(sl_b), .sl_e(sl_e), .sl_g(sl_g), .sl_l(sl_l),
    .busy(busy), .done(done), .e(e), .g(g), .l(l)
  );

  // Pulse start with operands, then count busy cycles until done (bounded).
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        output int nbusy, output int done_cyc);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nbusy = 0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int nb, dc;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #3;
    n_checks++;
    if ({busy, done, e, g, l, sl_a, sl_b} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got busy/done/e/g/l/sl_a/sl_b=%b required 0000000", {busy, done, e, g, l, sl_a, sl_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Result must be cleared by a reset taken while idle.
    run_op(8'h12, 8'h13, nb, dc);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({e, g, l} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_clears_result: got e/g/l=%b required 000", {e, g, l});
    end
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] egl;
    int         nbusy;
    int         dcyc;
  } vec_t;

  task automatic test_compare();
    vec_t vecs[7];
    int nb, dc;
    vecs[0] = '{8'hA5, 8'hA5, 3'b100, 4, 5};
    vecs[1] = '{8'hC0, 8'h80, 3'b010, 1, 2};
    vecs[2] = '{8'h12, 8'h13, 3'b001, 4, 5};
    vecs[3] = '{8'h37, 8'h34, 3'b010, 4, 5};
    vecs[4] = '{8'h38, 8'h34, 3'b010, 3, 4};
    vecs[5] = '{8'h10, 8'h20, 3'b001, 2, 3};
    vecs[6] = '{8'h00, 8'hFF, 3'b001, 1, 2};
    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, nb, dc);
      n_checks++;
      if ({e, g, l} !== vecs[i].egl) begin
        n_fail++;
        $display("FAIL cmp_result[%0d] %h vs %h: got e/g/l=%b required %b", i, vecs[i].va, vecs[i].vb, {e, g, l}, vecs[i].egl);
      end
      n_checks++;
      if (nb !== vecs[i].nbusy) begin
        n_fail++;
        $display("FAIL cmp_busy_cycles[%0d]: got %0d required %0d", i, nb, vecs[i].nbusy);
      end
      n_checks++;
      if (dc !== vecs[i].dcyc) begin
        n_fail++;
        $display("FAIL cmp_done_cycle[%0d]: got %0d required %0d", i, dc, vecs[i].dcyc);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cmp_busy_in_done[%0d]: got %b required 0", i, busy);
      end
    end
  endtask

  task automatic test_slices();
    logic [1:0] exp_a[4];
    logic [1:0] exp_b[4];
    // A5 = 10 10 01 01, A6 = 10 10 01 10 ; equal down to idx 0, then less
    exp_a = '{2'b10, 2'b10, 2'b01, 2'b01};
    exp_b = '{2'b10, 2'b10, 2'b01, 2'b10};
    @(negedge clk);
    n_checks++;
    if ({sl_a, sl_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL slice_idle: got sl_a/sl_b=%b required 0000", {sl_a, sl_b});
    end
    a = 8'hA5; b = 8'hA6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (sl_a !== exp_a[c] || sl_b !== exp_b[c]) begin
        n_fail++;
        $display("FAIL slice[%0d]: got sl_a=%b sl_b=%b required %b %b", c, sl_a, sl_b, exp_a[c], exp_b[c]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({done, sl_a, sl_b, e, g, l} !== 8'b1_0000_001) begin
      n_fail++;
      $display("FAIL slice_done: got done/sl_a/sl_b/e/g/l=%b required 10000001", {done, sl_a, sl_b, e, g, l});
    end
  endtask

  task automatic test_start_ignored();
    int dc = -1;
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({e, g, l} !== 3'b000) begin
          n_fail++;
          $display("FAIL result_cleared_on_start: got e/g/l=%b required 000", {e, g, l});
        end
      end
      if (c == 2) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (done) begin dc = c; break; end
    end
    start = 1'b0;
    n_checks++;
    if (dc !== 5 || {e, g, l} !== 3'b001) begin
      n_fail++;
      $display("FAIL start_ignored: got done_cycle=%0d e/g/l=%b required 5 001", dc, {e, g, l});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, e, g, l} !== 4'b0001) begin
      n_fail++;
      $display("FAIL result_hold: got busy/e/g/l=%b required 0001", {busy, e, g, l});
    end
  endtask

  task automatic test_reset_abort();
    int nb, dc;
    logic saw_done = 1'b0;
    logic saw_busy = 1'b0;
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, e, g, l, sl_a, sl_b} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy/done/e/g/l/sl_a/sl_b=%b required 0000000", {busy, done, e, g, l, sl_a, sl_b});
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_checks++;
    if ({saw_done, saw_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_no_done: got saw_done/saw_busy=%b required 00", {saw_done, saw_busy});
    end
    run_op(8'hC0, 8'h80, nb, dc);
    n_checks++;
    if (dc !== 2 || nb !== 1 || {e, g, l} !== 3'b010) begin
      n_fail++;
      $display("FAIL after_reset_op: got done_cycle=%0d busy=%0d e/g/l=%b required 2 1 010", dc, nb, {e, g, l});
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int nb = 0;
    @(negedge clk);
    a = 8'h40; b = 8'h40; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        done_at.push_back(c);
        n_checks++;
        if ({e, g, l} !== 3'b100) begin
          n_fail++;
          $display("FAIL b2b_result at cycle %0d: got e/g/l=%b required 100", c, {e, g, l});
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (done_at.size() !== 3 || done_at[0] !== 5 || done_at[1] !== 11 || done_at[2] !== 17) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got %0d pulses first=%0d required 3 pulses at 5 11 17",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    n_checks++;
    if (nb !== 12) begin
      n_fail++;
      $display("FAIL b2b_busy_cycles: got %0d required 12", nb);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_compare();
    test_slices();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_seq_ctrl.md
COMPARATOR_SEQ_CTRL -- requirements
Module: comparator_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to compare a against b; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, unsigned.
REQ-006 Port: b  input  WIDTH  operand B, unsigned.
REQ-007 Port: sl_a  output  2  current 2-bit slice of latched A, driven to the external 2-bit slice comparator.
REQ-008 Port: sl_b  output  2  current 2-bit slice of latched B, driven to the external 2-bit slice comparator.
REQ-009 Port: sl_e, sl_g, sl_l  input  1 each  slice-comparator results (sl_a==sl_b, sl_a>sl_b, sl_a<sl_b); combinational from sl_a/sl_b.
REQ-010 Port: busy  output  1  high while an operation is in progress (state COMPARE).
REQ-011 Port: done  output  1  one-cycle pulse; result valid.
REQ-012 Port: e, g, l  output  1 each  registered final result A==B, A>B, A<B; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, COMPARE, DONE; encoding free.
REQ-014 IDLE with start=1 at a rising edge SHALL latch a and b, set slice index idx=WIDTH/2-1, clear e/g/l to 0, and enter COMPARE.
REQ-015 IDLE with start=0 SHALL remain in IDLE; e/g/l SHALL hold.
REQ-016 In COMPARE, sl_a/sl_b SHALL equal latched A/B bits [2*idx+1:2*idx] (MSB slice first); outside COMPARE they SHALL be 2'b00.
REQ-017 In COMPARE, slice results SHALL be decoded with priority sl_g > sl_l > sl_e; all three low SHALL be treated as equal.
REQ-018 A slice decoded as greater SHALL set g=1 and enter DONE at that edge.
REQ-019 A slice decoded as less SHALL set l=1 and enter DONE at that edge.
REQ-020 A slice decoded as equal with idx>0 SHALL decrement idx and remain in COMPARE.
REQ-021 A slice decoded as equal with idx==0 SHALL set e=1 and enter DONE.
REQ-022 Exactly one of e/g/l SHALL be high after any completed operation.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-024 start SHALL be ignored in COMPARE and DONE; it is not queued.
REQ-025 a and b SHALL be ignored after capture; changes do not affect the operation in progress.
REQ-026 Latency: with the first decisive slice at index k (k = WIDTH/2-1 down to 0), COMPARE SHALL last WIDTH/2-k cycles, followed by one DONE cycle.
REQ-027 Worst case: WIDTH/2 COMPARE cycles + 1 DONE cycle; best case: 1 + 1.
REQ-028 busy and done SHALL be registered (state-decoded) and glitch-free.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, e=g=l=0, sl_a=sl_b=0, idx=0, and clear latched operands, regardless of clk.
REQ-030 Reset during COMPARE or DONE SHALL abort the operation with no done pulse.
REQ-031 After rst_n rises, the first start SHALL be accepted at the next rising edge.

Verification (WIDTH=8, ideal slice comparator attached)
REQ-032 a=8'hA5, b=8'hA5, start pulse -> busy high 4 cycles, done on cycle 5 after the capture edge, e=1, g=l=0.
REQ-033 a=8'hC0, b=8'h80 -> first slice 2'b11 vs 2'b10, g=1, busy 1 cycle, done on the following cycle.
REQ-034 a=8'h12, b=8'h13 -> slices equal until idx 0 (2'b10 vs 2'b11), l=1 after 4 COMPARE cycles.
REQ-035 start re-pulsed with a=8'hFF, b=8'h00 during an 8'h12/8'h13 operation -> ignored; result l=1; e/g/l hold afterward.
REQ-036 rst_n low for 3 ns in the 2nd COMPARE cycle -> all outputs 0 asynchronously, no done; a new start after release completes normally.
REQ-037 start held high continuously with 8'h40 vs 8'h40 -> back-to-back operations, each 4 COMPARE + 1 DONE + 1 IDLE cycles, e=1 each time.
